// File: rtl/morse_keyer.sv
`default_nettype none
// ============================================================================
// Module      : morse_keyer
// Description : Keys a 1..4 symbol Morse pattern onto key_out with unit-based
//               mark, intra-letter space and letter-gap timing.
// Revision    : 1.0 - initial release
// ============================================================================
module morse_keyer #(
  parameter int UNIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] code,
  input  logic [1:0] len,
  input  logic       start,
  output logic       ready,
  output logic       busy,
  output logic       key_out,
  output logic       done
);

  localparam int c_cnt_w = $clog2(3 * UNIT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_dot  = c_cnt_w'(UNIT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_dash = c_cnt_w'(3 * UNIT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2,
    ST_LGAP  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic [1:0]         r_idx;
  logic [1:0]         w_idx_nxt;
  logic [3:0]         r_code;
  logic [3:0]         w_code_nxt;
  logic               w_done_nxt;
  logic               w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  // The counter holds the remaining cycles minus one of the current state,
  // so each state ends on the cycle where it reads zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_code_nxt  = r_code;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_MARK;
          w_code_nxt  = code;
          w_idx_nxt   = len;
          w_cnt_nxt   = code[len] ? c_dash : c_dot;
        end
      end
      ST_MARK: begin
        if (w_cnt_zero) begin
          if (r_idx == 2'd0) begin
            w_state_nxt = ST_LGAP;
            w_cnt_nxt   = c_dash;
          end else begin
            w_state_nxt = ST_SPACE;
            w_cnt_nxt   = c_dot;
            w_idx_nxt   = r_idx - 2'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - c_one;
        end
      end
      ST_SPACE: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_MARK;
          w_cnt_nxt   = r_code[r_idx] ? c_dash : c_dot;
        end else begin
          w_cnt_nxt = r_cnt - c_one;
        end
      end
      ST_LGAP: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - c_one;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= 2'd0;
      r_code  <= 4'd0;
      key_out <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      ready   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_code  <= w_code_nxt;
      key_out <= (w_state_nxt == ST_MARK);
      done    <= w_done_nxt;
      busy    <= (w_state_nxt != ST_IDLE);
      ready   <= (w_state_nxt == ST_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_morse_keyer.sv
`default_nettype none
// Scoreboard bench: two keyers (UNIT_CYCLES 2 and 1) checked cycle by cycle
// against a timeline model built from symbol/space/gap durations.
module tb_morse_keyer;

  localparam int U0 = 2;
  localparam int U1 = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] code0 = 4'd0, code1 = 4'd0;
  logic [1:0] len0 = 2'd0, len1 = 2'd0;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic       ready0, busy0, key0, done0;
  logic       ready1, busy1, key1, done1;

  int checks = 0;
  int errors = 0;

  logic [3:0] q0[$];
  logic [3:0] q1[$];

  morse_keyer #(.UNIT_CYCLES(U0)) dut0 (
    .clk(clk), .rst_n(rst_n), .code(code0), .len(len0), .start(start0),
    .ready(ready0), .busy(busy0), .key_out(key0), .done(done0)
  );

  morse_keyer #(.UNIT_CYCLES(U1)) dut1 (
    .clk(clk), .rst_n(rst_n), .code(code1), .len(len1), .start(start1),
    .ready(ready1), .busy(busy1), .key_out(key1), .done(done1)
  );

  always #5 clk = ~clk;

  // Cycle index (1 = cycle after acceptance) of the done pulse.
  function automatic int letter_len(input int u, input logic [3:0] c, input int l);
    int n = 0;
    for (int i = 0; i <= l; i++) n += c[i] ? 3 * u : u;
    return n + l * u + 3 * u + 1;
  endfunction

  // Expected keying line at cycle t, walking the mark/space timeline.
  function automatic logic exp_key(input int u, input logic [3:0] c, input int l, input int t);
    int pos = 1;
    for (int i = l; i >= 0; i--) begin
      int d = c[i] ? 3 * u : u;
      if (t < pos + d) return 1'b1;
      pos += d;
      if (i > 0) begin
        if (t < pos + u) return 1'b0;
        pos += u;
      end
    end
    return 1'b0;
  endfunction

  task automatic push_trace(input int which, input int u, input logic [3:0] c, input int l);
    int tt = letter_len(u, c, l);
    for (int t = 1; t <= tt; t++) begin
      logic [3:0] e;
      e = (t == tt) ? 4'b0011 : {exp_key(u, c, l, t), 3'b100};
      if (which == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic set_in(input int which, input logic s, input logic [3:0] c, input logic [1:0] l);
    if (which == 0) begin
      start0 = s; code0 = c; len0 = l;
    end else begin
      start1 = s; code1 = c; len1 = l;
    end
  endtask

  // Called in a cycle where the keyer is ready; returns in a ready cycle.
  task automatic send(input int which, input logic [3:0] c, input logic [1:0] l,
                      input int gap, input bit noise, input int pulse_at);
    int u = (which == 0) ? U0 : U1;
    int tt;
    set_in(which, 1'b1, c, l);
    @(posedge clk); #1;
    tt = letter_len(u, c, int'(l));
    push_trace(which, u, c, int'(l));
    for (int t = 1; t < tt; t++) begin
      if (t == pulse_at) set_in(which, 1'b1, ~c, 2'd3);
      else if (noise) set_in(which, ($urandom_range(0, 3) == 0), 4'($urandom), 2'($urandom));
      else set_in(which, 1'b0, c, l);
      @(posedge clk); #1;
    end
    set_in(which, 1'b0, noise ? 4'($urandom) : c, l);
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_mid(input logic [3:0] c, input logic [1:0] l, input int at);
    logic [3:0] a;
    set_in(0, 1'b1, c, l);
    @(posedge clk); #1;
    push_trace(0, U0, c, int'(l));
    set_in(0, 1'b0, c, l);
    for (int t = 1; t < at; t++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    a = {key0, busy0, ready0, done0};
    checks++;
    if (a !== 4'b0010) begin
      errors++;
      $display("FAIL async_reset {key_out,busy,ready,done} got=%b exp=0010", a);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [3:0] a, e;
    a = {key0, busy0, ready0, done0};
    e = 4'b0010;
    if (q0.size() > 0) e = q0.pop_front();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL dut0_outputs t=%0t {key_out,busy,ready,done} got=%b exp=%b", $time, a, e);
    end
    a = {key1, busy1, ready1, done1};
    e = 4'b0010;
    if (q1.size() > 0) e = q1.pop_front();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL dut1_outputs t=%0t {key_out,busy,ready,done} got=%b exp=%b", $time, a, e);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Directed letters on the UNIT_CYCLES=2 keyer.
    send(0, 4'b0000, 2'd0, 3, 1'b0, -1);   // E
    send(0, 4'b0010, 2'd1, 2, 1'b0, -1);   // N
    send(0, 4'b1101, 2'd3, 1, 1'b0, -1);   // Q
    send(0, 4'b0000, 2'd0, 0, 1'b0, -1);   // E, then N back-to-back
    send(0, 4'b0010, 2'd1, 2, 1'b0, 9);    // start pulse in N's second mark
    send(0, 4'b1110, 2'd0, 1, 1'b1, -1);   // high bits ignored, noisy inputs
    reset_mid(4'b1101, 2'd3, 3);           // reset during Q's first mark
    send(0, 4'b0111, 2'd2, 0, 1'b1, -1);   // acceptance right after release
    for (int n = 0; n < 40; n++)
      send(0, 4'($urandom), 2'($urandom), $urandom_range(0, 2) == 0 ? 0 : $urandom_range(1, 3),
           bit'($urandom_range(0, 1)), -1);
    // Minimum unit length on the second keyer.
    send(1, 4'b0000, 2'd0, 1, 1'b0, -1);
    send(1, 4'b0010, 2'd1, 0, 1'b0, -1);
    send(1, 4'b1101, 2'd3, 2, 1'b0, -1);
    for (int n = 0; n < 30; n++)
      send(1, 4'($urandom), 2'($urandom), $urandom_range(0, 2),
           bit'($urandom_range(0, 1)), -1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending got=%0d/%0d exp=0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/morse_keyer.md
MORSE_KEYER -- requirements
Module: morse_keyer

Interface
REQ-001 Parameter UNIT_CYCLES, default 4, meaning clock cycles per Morse time unit; legal range 1..255.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 code  input  4  symbol pattern from the encoder stage; 1 = dash, 0 = dot; only bits code[len:0] are used; higher bits are ignored.
REQ-005 len  input  2  symbol count minus one, from the encoder's num field (0 -> 1 symbol, 3 -> 4 symbols).
REQ-006 start  input  1  request to key the pattern on code/len; sampled on clk.
REQ-007 ready  output  1  high when the block can accept start (IDLE only).
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 key_out  output  1  keying line: 1 = tone on (mark), 0 = tone off.
REQ-010 done  output  1  one-cycle pulse when a letter, including its trailing gap, completes.

Function
REQ-011 States: IDLE, MARK, SPACE, LGAP; all outputs are registered.
REQ-012 Acceptance: start high while ready high, at a rising edge; code and len are captured into internal registers at that edge.
REQ-013 start while busy is ignored: no capture, no effect on the letter in progress.
REQ-014 Symbol order: code[len] is keyed first, code[0] last.
REQ-015 IDLE -> MARK on acceptance; key_out rises in the cycle after the start cycle (latency 1).
REQ-016 MARK duration: UNIT_CYCLES cycles for a dot, 3*UNIT_CYCLES cycles for a dash; key_out = 1 throughout.
REQ-017 MARK -> SPACE when more symbols remain; SPACE lasts UNIT_CYCLES cycles with key_out = 0, then returns to MARK for the next symbol.
REQ-018 MARK -> LGAP after the last symbol; LGAP lasts 3*UNIT_CYCLES cycles with key_out = 0.
REQ-019 LGAP -> IDLE; done = 1 and ready = 1 in the first IDLE cycle.
REQ-020 A start asserted in that done cycle is accepted, giving back-to-back letters with no extra idle cycle.
REQ-021 Duration counter width: at least ceil(log2(3*UNIT_CYCLES+1)) bits; it reloads on every state entry and never wraps mid-state.
REQ-022 Symbol index counter: 2 bits, loaded with the captured len, decremented after each MARK; the last symbol is the one whose index is 0.
REQ-023 Input changes on code/len after acceptance shall not alter the letter in progress.
REQ-024 UNIT_CYCLES = 1 shall work: dot = 1 cycle, dash = 3 cycles, intra-letter space = 1 cycle, letter gap = 3 cycles.

Reset
REQ-025 rst_n low forces, asynchronously: state = IDLE, key_out = 0, done = 0, busy = 0, ready = 1, all counters and capture registers = 0.
REQ-026 Reset asserted mid-letter aborts the letter immediately with no done pulse.
REQ-027 After rst_n rises, the first acceptance is possible on the next rising edge.

Verification (UNIT_CYCLES = 2, start accepted at cycle 0)
REQ-028 E: code = 0000, len = 0 -> key_out high in cycles 1-2 and low in cycles 3-8; done and ready high in cycle 9.
REQ-029 N: code = 0010, len = 1 -> key_out high 6, low 2, high 2, low 6 cycles; done in cycle 17.
REQ-030 Q: code = 1101, len = 3 -> marks of 6/6/2/6 cycles separated by 2-cycle spaces, then a 6-cycle gap; done in cycle 33.
REQ-031 Back-to-back: E, then start held high in E's done cycle with N on the inputs -> N's first mark begins in cycle 10.
REQ-032 Busy and reset cases: start pulsed with a different code during N's second mark -> output is unchanged; rst_n low during Q's first mark -> key_out = 0 and ready = 1 immediately, with no done pulse.
